// File: rtl/pwm_frame_loader.sv
// pwm_frame_loader
//   Parses framed duty-cycle updates from the serial receive byte stream,
//   validates them with an XOR checksum, stages a good frame in a pending
//   bank and commits all channels together on the next PWM period boundary.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx_data      received byte, valid while new_rx_data is high
//   new_rx_data  byte-valid flag, one byte consumed per rising edge
//   period_start one-cycle pulse from the PWM counter wrap
//   duty         active duty values, channel n at [n*DUTY_W +: DUTY_W]
//   busy         parser is not idle
//   pending      a validated frame waits for period_start
//   frame_ok     one-cycle pulse, frame accepted
//   frame_err    one-cycle pulse, frame rejected
//   err_count    saturating rejected-frame counter
//   dbg_state_o  parser state, for debug/observation
//
// Byte handshake: there is no back-pressure. A byte is taken exactly once,
// in the cycle where new_rx_data is high and was low the cycle before;
// holding new_rx_data high does not repeat the byte.
module pwm_frame_loader #(
  parameter int         NUM_CH      = 11,
  parameter int         DUTY_W      = 8,
  parameter logic [7:0] SYNC        = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     new_rx_data,
  input  logic                     period_start,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic                     busy,
  output logic                     pending,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic [7:0]               err_count,
  output logic [1:0]               dbg_state_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [7:0]                xor_q, xor_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [NUM_CH*DUTY_W-1:0]  stage_q, stage_d;
  logic [NUM_CH*DUTY_W-1:0]  bank_q;
  logic [NUM_CH*DUTY_W-1:0]  duty_q;
  logic                      rx_prev_q;
  logic                      pending_q, pending_d;
  logic                      ok_q, ok_d;
  logic                      err_q, err_d;
  logic [7:0]                err_cnt_q;
  logic                      accept;
  logic                      commit;

  assign accept = new_rx_data & ~rx_prev_q;
  assign commit = period_start & pending_q;

  // Parser next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    stage_d = stage_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    // Inter-byte timer only runs while a frame is open.
    if (accept || state_q == ST_IDLE) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (state_q != ST_IDLE && !accept && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      idx_d   = '0;
      stage_d = '0;
      tmo_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (rx_data == 8'h01) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
            xor_d   = rx_data;
          end else if (rx_data == 8'h00) begin
            state_d = ST_CHECK;
            stage_d = '0;
            xor_d   = rx_data;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (idx_q == IDX_W'(n)) stage_d[n*DUTY_W +: DUTY_W] = rx_data[DUTY_W-1:0];
          end
          xor_d = xor_q ^ rx_data;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_CHECK: begin
          if (rx_data == xor_q) ok_d = 1'b1;
          else                  err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A commit and a new validation on the same edge: the old bank goes to
  // duty while the new frame becomes pending for the following period.
  always_comb begin
    pending_d = commit ? 1'b0 : pending_q;
    if (ok_d) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      xor_q     <= '0;
      tmo_q     <= '0;
      stage_q   <= '0;
      bank_q    <= '0;
      duty_q    <= '0;
      rx_prev_q <= 1'b0;
      pending_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      tmo_q     <= tmo_d;
      stage_q   <= stage_d;
      rx_prev_q <= new_rx_data;
      pending_q <= pending_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      if (ok_d)   bank_q <= stage_q;
      if (commit) duty_q <= bank_q;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign duty        = duty_q;
  assign busy        = (state_q != ST_IDLE);
  assign pending     = pending_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign err_count   = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule
